serial_subtractor_4bits: RTL and testbench

//   Bit-serial subtractor: computes d = a - b - bi (LSB first, one bit per clock),

---
 rtl/serial_subtractor_4bits_pkg.sv | 21 ++
 rtl/serial_subtractor_4bits_full_subtractor_1bit.sv | 15 +
 rtl/serial_subtractor_4bits.sv | 97 +++++++++
 tb/tb_serial_subtractor_4bits.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_4bits_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the counter-width helper.
package serial_subtractor_4bits_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_subtractor_4bits_full_subtractor_1bit.sv
// One-bit full subtractor: diff = x - y - bin, with borrow-out.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    always_comb begin
        diff = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor_4bits.sv
// Bit-serial subtractor d = a - b - bi, LSB first, one bit per clock, with a
// start/busy/done handshake toward the controlling sequencer.
module serial_subtractor_4bits
    import serial_subtractor_4bits_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int CNT_W = clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             br;
    logic             diff_bit;
    logic             bout_bit;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] r_next;

    full_subtractor_1bit u_fs (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .bin (br),
        .diff(diff_bit),
        .bout(bout_bit)
    );

    // A new operation may start from IDLE or straight out of DONE.
    assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign r_next   = {diff_bit, r_sr[WIDTH-1:1]};
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = accept ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nxt = last_bit ? ST_DONE : ST_RUN;
            ST_DONE: state_nxt = accept ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: operands shift right, result fills in from the MSB side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            br   <= 1'b0;
            d    <= '0;
            bo   <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            a_sr <= a;
            b_sr <= b;
            r_sr <= '0;
            br   <= bi;
        end else if (state == ST_RUN) begin
            cnt  <= cnt + 1'b1;
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= r_next;
            br   <= bout_bit;
            if (last_bit) begin
                d  <= r_next;
                bo <= bout_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_4bits.sv
// Directed and exhaustive checks of the bit-serial subtractor handshake,
// arithmetic, back-to-back issue, busy lockout and asynchronous reset.
module tb_serial_subtractor_4bits;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic       bo;

    int total;
    int bad;
    logic [3:0] prev_d;

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic       vbi;
        logic [3:0] ed;
        logic       ebo;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor_4bits #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bi   (bi),
        .busy (busy),
        .done (done),
        .d    (d),
        .bo   (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Waits for the done pulse; lat0 is the number of RUN edges already elapsed.
    task automatic wait_done(input string nm, input logic [3:0] ed, input logic ebo, input int lat0);
        int lat;
        bit seen;
        lat  = lat0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
            else begin
                chk({nm, " busy_run"}, busy, 1);
                chk({nm, " d_hold"}, d, prev_d);
            end
        end
        chk({nm, " latency"}, lat, 4);
        chk({nm, " d"}, d, ed);
        chk({nm, " bo"}, bo, ebo);
        chk({nm, " busy_at_done"}, busy, 0);
        prev_d = ed;
    endtask

    task automatic run_op(input string nm, input logic [3:0] ta, input logic [3:0] tb_,
                          input logic tbi, input logic [3:0] ed, input logic ebo);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; bi = tbi;
        @(posedge clk); #1;
        start = 1'b0;
        a  = 4'($urandom_range(15));
        b  = 4'($urandom_range(15));
        bi = 1'($urandom_range(1));
        chk({nm, " busy_after_accept"}, busy, 1);
        wait_done(nm, ed, ebo, 0);
    endtask

    initial begin
        int dones;
        logic [4:0] full;
        logic       mbo;

        total = 0; bad = 0; prev_d = 4'h0;
        vecs[0] = '{4'h3, 4'h2, 1'b0, 4'h1, 1'b0};
        vecs[1] = '{4'h1, 4'h2, 1'b0, 4'hF, 1'b1};
        vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
        vecs[3] = '{4'hF, 4'h1, 1'b1, 4'hD, 1'b0};
        vecs[4] = '{4'h5, 4'h3, 1'b0, 4'h2, 1'b0};
        vecs[5] = '{4'h0, 4'hF, 1'b0, 4'h1, 1'b1};
        vecs[6] = '{4'hA, 4'h5, 1'b1, 4'h4, 1'b0};
        vecs[7] = '{4'h9, 4'h9, 1'b1, 4'hF, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0; bi = 1'b0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset d", d, 0);
        chk("reset bo", bo, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vbi,
                   vecs[i].ed, vecs[i].ebo);
        end

        // Back-to-back: start held high through DONE issues the second op.
        @(negedge clk);
        start = 1'b1; a = 4'hF; b = 4'h1; bi = 1'b1;
        @(posedge clk); #1;
        a = 4'h8; b = 4'h8; bi = 1'b0;
        chk("b2b first busy", busy, 1);
        wait_done("b2b first", 4'hD, 1'b0, 0);
        @(posedge clk); #1;
        chk("b2b reissue busy", busy, 1);
        chk("b2b reissue done", done, 0);
        chk("b2b reissue d_hold", d, 4'hD);
        start = 1'b0;
        wait_done("b2b second", 4'h0, 1'b0, 0);

        // Start while busy must be ignored.
        @(negedge clk);
        start = 1'b1; a = 4'h5; b = 4'h3; bi = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'h0; b = 4'h1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignore", 4'h2, 1'b0, 1);
        dones = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("busy_ignore extra done", dones, 0);
        chk("busy_ignore idle busy", busy, 0);

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        start = 1'b1; a = 4'h7; b = 4'h1; bi = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort d", d, 0);
        chk("abort bo", bo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_d = 4'h0;
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        chk("abort no activity", dones, 0);

        // Exhaustive sweep against an arithmetic reference.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    full = 5'(ia) - 5'(ib) - 5'(ic);
                    mbo  = (ia < ib + ic);
                    run_op($sformatf("sweep a=%0d b=%0d bi=%0d", ia, ib, ic),
                           4'(ia), 4'(ib), 1'(ic), full[3:0], mbo);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
